// File: rtl/key_expander.sv
// AES key schedule generator: streams the expanded key as 128-bit round keys
// over a valid/ready interface, one 32-bit schedule word per advancing cycle.
module key_expander #(
  parameter logic [2:0] MODE_MASK = 3'b111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at the top of the table, so ~b*8 is its offset from bit 0.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0][31:0] win_q;
  logic [95:0]      acc_q;
  logic [5:0]       i_q;
  logic [2:0]       pos_q;
  logic [2:0]       nkm1_q;
  logic [3:0]       nr_q;
  logic [7:0]       rc_q;
  logic             first_q;
  logic             gen_q;

  logic             mode_ok;
  logic [2:0]       nkm1_sel;
  logic [3:0]       nr_sel;
  logic [7:0][31:0] key_win;
  logic             start_ok, start_bad, xfer, final_xfer, advance;
  logic [31:0]      w_prev, w_back, rot_w, sub_w, t_w, w_new;

  always_comb begin
    mode_ok  = 1'b0;
    nkm1_sel = 3'd3;
    nr_sel   = 4'd10;
    case (mode)
      2'b00: mode_ok = MODE_MASK[0];
      2'b01: begin
        mode_ok  = MODE_MASK[1];
        nkm1_sel = 3'd5;
        nr_sel   = 4'd12;
      end
      2'b10: begin
        mode_ok  = MODE_MASK[2];
        nkm1_sel = 3'd7;
        nr_sel   = 4'd14;
      end
      default: mode_ok = 1'b0;
    endcase
  end

  // Preload so that slot Nk-1 holds key word 0; each shift then exposes the
  // next key word there, which is also where w[i-Nk] lives once i >= Nk.
  always_comb begin
    key_win = '0;
    for (int j = 0; j < 8; j++) begin
      if (j <= int'(nkm1_sel))
        key_win[j] = key[32 * (7 - int'(nkm1_sel) + j) +: 32];
    end
  end

  assign start_ok   = start && (state_q == IDLE) && mode_ok;
  assign start_bad  = start && (state_q == IDLE) && !mode_ok;
  assign xfer       = rk_valid && rk_ready;
  assign final_xfer = (state_q == RUN) && xfer && !gen_q && (rk_idx == nr_q);
  assign advance    = gen_q && !(rk_valid && !rk_ready);
  assign busy       = (state_q == RUN);

  always_comb begin
    w_prev = win_q[0];
    w_back = win_q[nkm1_q];
    rot_w  = {w_prev[23:0], w_prev[31:24]};
    sub_w  = sub_word((pos_q == 3'd0) ? rot_w : w_prev);
    t_w    = w_prev;
    if (pos_q == 3'd0)
      t_w = sub_w ^ {rc_q, 24'h0};
    else if ((nkm1_q == 3'd7) && (pos_q == 3'd4))
      t_w = sub_w;
    w_new = first_q ? w_back : (w_back ^ t_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (final_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      pos_q    <= '0;
      nkm1_q   <= '0;
      nr_q     <= '0;
      rc_q     <= '0;
      first_q  <= 1'b0;
      gen_q    <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= final_xfer;
      err  <= start_bad;

      if (start_ok) begin
        win_q   <= key_win;
        acc_q   <= '0;
        i_q     <= '0;
        pos_q   <= '0;
        nkm1_q  <= nkm1_sel;
        nr_q    <= nr_sel;
        rc_q    <= 8'h01;
        first_q <= 1'b1;
        gen_q   <= 1'b1;
      end else if (advance) begin
        win_q <= {win_q[6:0], w_new};
        i_q   <= i_q + 6'd1;
        if (pos_q == nkm1_q) begin
          pos_q   <= '0;
          first_q <= 1'b0;
        end else begin
          pos_q <= pos_q + 3'd1;
        end
        if ((pos_q == 3'd0) && !first_q)
          rc_q <= xtime(rc_q);
        if (i_q == {nr_q, 2'b11})
          gen_q <= 1'b0;
        if (i_q[1:0] == 2'b11) begin
          rk_data <= {acc_q, w_new};
          rk_idx  <= i_q[5:2];
        end else begin
          acc_q <= {acc_q[63:0], w_new};
        end
      end

      if (advance && (i_q[1:0] == 2'b11))
        rk_valid <= 1'b1;
      else if (xfer)
        rk_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: an independent FIPS-197 key schedule model fills a
// scoreboard; published round keys, timing, stalls, errors and reset are checked.
module tb_key_expander;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic [1:0]   mode;
  logic [255:0] key;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_valid, busy, done, err;

  logic         start2;
  logic [1:0]   mode2;
  logic [255:0] key2;
  logic [127:0] rk_data2;
  logic [3:0]   rk_idx2;
  logic         rk_valid2, busy2, done2, err2;

  always #5 clk = ~clk;

  key_expander dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done), .err(err)
  );

  key_expander #(.MODE_MASK(3'b011)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .key(key2),
    .rk_data(rk_data2), .rk_idx(rk_idx2), .rk_valid(rk_valid2), .rk_ready(1'b1),
    .busy(busy2), .done(done2), .err(err2)
  );

  int           tests = 0;
  int           fails = 0;
  logic [131:0] exp_q[$];
  logic [127:0] cap[16];
  int           ncap = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  bit           chk_lat = 1'b0;
  bit           expect_done = 1'b0;
  bit           prev_stall = 1'b0;
  logic [131:0] prev_rk = '0;
  int           err_cnt = 0;
  logic [7:0]   sb[256];

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    int           ia;
    logic [127:0] ea;
    int           ib;
    logic [127:0] eb;
    int           nkeys;
  } vec_t;
  vec_t tv[3];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] b8, x8, inv;
    for (int b = 0; b < 256; b++) begin
      b8  = 8'(b);
      inv = 8'h00;
      if (b != 0)
        for (int x = 1; x < 256; x++) begin
          x8 = 8'(x);
          if (gmul(b8, x8) == 8'h01) inv = x8;
        end
      sb[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_push(input logic [1:0] m, input logic [255:0] k);
    logic [31:0] w[60];
    logic [31:0] t;
    int nk, nr;
    nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = subw(t);
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      exp_q.push_back({4'(r), w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]});
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done || expect_done) check("done_pulse", done, expect_done);
      if (expect_done) check("busy_after_done", busy, 1'b0);
      expect_done = 1'b0;
      if (err) err_cnt++;
      if (prev_stall) check("stall_hold", {rk_valid, rk_idx, rk_data}, {1'b1, prev_rk});
      if (rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rk got idx=%0d data=%h exp=none", rk_idx, rk_data);
        end else begin
          check("rk", {rk_idx, rk_data}, exp_q.pop_front());
          cap[rk_idx] = rk_data;
          ncap++;
          if (exp_q.size() == 0) expect_done = 1'b1;
        end
        if (chk_lat) check("latency", cyc - start_cyc, 4 * (rk_idx + 1));
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk    = {rk_idx, rk_data};
    end
  end

  // Called at #1 after a rising edge with the DUT able to accept a start.
  task automatic run_exp(input logic [1:0] m, input logic [255:0] k,
                         input bit rnd, input bit inj, input int maxc);
    int n;
    bit done_seen;
    model_push(m, k);
    for (int j = 0; j < 16; j++) cap[j] = '0;
    ncap      = 0;
    chk_lat   = !rnd;
    start_cyc = cyc + 1;
    mode      = m;
    key       = k;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_start", busy, 1'b1);
    n = 0;
    done_seen = 1'b0;
    while (!done_seen && n < maxc) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj && n == 10) begin
        start = 1'b1;
        mode  = 2'b01;
        key   = ~k;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
      n++;
    end
    start    = 1'b0;
    rk_ready = 1'b1;
    chk_lat  = 1'b0;
    check("done_seen", done_seen, 1'b1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_at_done", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n;
    tv[0] = '{2'b00, K128,
              1, 128'ha0fafe1788542cb123a339392a6c7605,
              10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 11};
    tv[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
              1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5,
              12, 128'he98ba06f448c773c8ecc720401002202, 13};
    tv[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
              2, 128'h9ba354118e6925afa51a8b5f2067fcde,
              14, 128'hfe4890d1e6188d0b046df344706c631e, 15};

    build_sbox();
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; key = '0; rk_ready = 1'b1;
    start2 = 1'b0; mode2 = 2'b00; key2 = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {rk_data, rk_idx, rk_valid, busy, done, err}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back runs: each start lands in the done cycle of the previous run.
    for (int v = 0; v < 3; v++) begin
      run_exp(tv[v].mode, tv[v].key, 1'b0, 1'b0, 200);
      check($sformatf("vec%0d_idx%0d", v, tv[v].ia), cap[tv[v].ia], tv[v].ea);
      check($sformatf("vec%0d_idx%0d", v, tv[v].ib), cap[tv[v].ib], tv[v].eb);
      check($sformatf("vec%0d_nkeys", v), ncap, tv[v].nkeys);
    end

    e0 = err_cnt;
    run_exp(2'b00, K128, 1'b1, 1'b1, 2000);
    check("stall_idx1", cap[1], tv[0].ea);
    check("stall_idx10", cap[10], tv[0].eb);
    check("stall_nkeys", ncap, 11);
    check("start_in_run_no_err", err_cnt - e0, 0);

    start = 1'b1; mode = 2'b11; key = {8{32'hdeadbeef}};
    @(posedge clk); #1;
    start = 1'b0;
    check("mode11_err", err, 1'b1);
    check("mode11_busy", busy, 1'b0);
    check("mode11_valid", rk_valid, 1'b0);
    @(posedge clk); #1;
    check("mode11_err_pulse", err, 1'b0);
    check("mode11_busy_after", busy, 1'b0);

    start2 = 1'b1; mode2 = 2'b10; key2 = K128;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("mask_err", err2, 1'b1);
    check("mask_busy", busy2, 1'b0);
    check("mask_valid", rk_valid2, 1'b0);
    start2 = 1'b1; mode2 = 2'b00;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("mask_ok_busy", busy2, 1'b1);
    check("mask_ok_err", err2, 1'b0);

    // Abort mid-run right after round key 5 has been taken.
    model_push(2'b00, K128);
    ncap = 0;
    start = 1'b1; mode = 2'b00; key = K128;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (ncap < 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_idx5", ncap, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {rk_data, rk_idx, rk_valid, busy, done, err}, '0);
    exp_q.delete();
    expect_done = 1'b0;
    prev_stall  = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {busy, done, rk_valid}, '0);
    run_exp(2'b00, K128, 1'b0, 1'b0, 200);
    check("fresh_idx1", cap[1], tv[0].ea);
    check("fresh_idx10", cap[10], tv[0].eb);
    check("fresh_nkeys", ncap, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_expander.md
KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 Parameter MODE_MASK, default 3'b111, enable mask for modes {bit0=AES-128, bit1=AES-192, bit2=AES-256}.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle request to expand key; accepted only in IDLE.
REQ-005 mode  in  2  key size select: 00=128, 01=192, 10=256, 11=invalid; sampled with start.
REQ-006 key  in  256  cipher key, left-aligned; w[0]=key[255:224]; unused low bits ignored; sampled with start.
REQ-007 rk_data  out  128  current round key {w[4k],w[4k+1],w[4k+2],w[4k+3]}.
REQ-008 rk_idx  out  4  round index k of rk_data.
REQ-009 rk_valid  out  1  rk_data/rk_idx valid.
REQ-010 rk_ready  in  1  consumer accepts; transfer when rk_valid&&rk_ready at clock edge.
REQ-011 busy  out  1  high from start acceptance until final transfer.
REQ-012 done  out  1  one-cycle pulse, cycle after final round key transfer.
REQ-013 err  out  1  one-cycle pulse on rejected start.

Function
REQ-014 States: IDLE, RUN; start with enabled valid mode: IDLE->RUN, latch key, Nk (4/6/8), Nr (10/12/14), word counter i=0.
REQ-015 start with mode=11 or mode bit clear in MODE_MASK: stay IDLE, err=1 next cycle, no other output change.
REQ-016 start while RUN: ignored, no err.
REQ-017 RUN produces exactly one 32-bit word w[i] per advancing cycle, in order i=0..4(Nr+1)-1 (44/52/60 words).
REQ-018 w[i], i<Nk: latched key word i; i>=Nk: w[i]=w[i-Nk]^t, t=w[i-1] transformed as follows.
REQ-019 i mod Nk==0: t=SubWord(RotWord(w[i-1]))^{Rcon[i/Nk],24'h0}; Rcon[1..10]=01,02,04,08,10,20,40,80,1b,36.
REQ-020 Nk==8 and i mod Nk==4: t=SubWord(w[i-1]); otherwise t=w[i-1].
REQ-021 SubWord = AES S-box on each of 4 bytes (4 combinational lookups); RotWord = left byte rotate.
REQ-022 History window holds last Nk words (max 8 x 32-bit shift register).
REQ-023 Words pack MSB-first into a 4-word accumulator; on 4th word, rk_data<=accumulator, rk_idx<=i/4, rk_valid<=1 at the same edge.
REQ-024 Advance rule: generation advances in a cycle iff !(rk_valid && !rk_ready); stall freezes i, window, accumulator.
REQ-025 rk_valid, rk_data, rk_idx held stable while rk_valid && !rk_ready.
REQ-026 rk_valid deasserts after transfer unless a new key loads at the same edge.
REQ-027 Latency with rk_ready=1: start accepted at edge 0; rk_idx=k valid for one cycle after edge 4(k+1); no bubbles.
REQ-028 Final transfer (rk_idx==Nr): RUN->IDLE, busy=0, done=1 for one cycle; next start accepted on that same cycle.
REQ-029 Rcon index never exceeds 10 in any mode (max used: 10/8/7).

Reset
REQ-030 rst_n low asynchronously forces IDLE; rk_data=0, rk_idx=0, rk_valid=0, busy=0, done=0, err=0, counters/window cleared.
REQ-031 Reset mid-RUN aborts expansion; no done pulse; first start after release behaves as from power-up.

Verification
REQ-032 AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx1=a0fafe1788542cb123a339392a6c7605, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6, 11 keys, done after idx10.
REQ-033 AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> idx1=62f8ead2522c6b7bfe0c91f72402f5a5, idx12=e98ba06f448c773c8ecc720401002202.
REQ-034 AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> idx2=9ba354118e6925afa51a8b5f2067fcde, idx14=fe4890d1e6188d0b046df344706c631e.
REQ-035 AES-128 with random rk_ready stalls -> identical key sequence, no skipped/duplicated idx, data stable while stalled.
REQ-036 mode=11, and mode=10 with MODE_MASK=3'b011 -> err pulse, busy stays 0, rk_valid stays 0; start during RUN -> ignored.
REQ-037 rst_n low after idx5 -> all outputs zero immediately; fresh AES-128 run afterwards matches REQ-032.
